// File: rtl/powlib_ipmaxi_wrarb.sv
// powlib_ipmaxi_wrarb: round-robin write arbiter in front of one AXI write master.
// Locks the grant for a whole requester transaction (capped at MAX_BURST beats)
// so the downstream master can pack contiguous beats into bursts.
// Optional feature: define POWLIB_IPMAXI_WRARB_TIMEOUT_EN to force a release
// after TIMEOUT consecutive idle cycles of the granted requester.

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif

module powlib_ipmaxi_wrarb #(
  parameter int unsigned N         = 2,
  parameter int unsigned B_AW      = 32,
  parameter int unsigned B_BPD     = 4,
  parameter int unsigned MAX_BURST = 128,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned B_DW     = `POWLIB_BW * B_BPD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*B_AW-1:0]   reqaddr,
  input  logic [N*B_DW-1:0]   reqdata,
  input  logic [N*B_BPD-1:0]  reqbe,
  input  logic [N-1:0]        reqlast,
  input  logic [N-1:0]        reqvld,
  output logic [N-1:0]        reqrdy,
  output logic [B_AW-1:0]     wraddr,
  output logic [B_DW-1:0]     wrdata,
  output logic [B_BPD-1:0]    wrbe,
  output logic                wrvld,
  input  logic                wrrdy,
  output logic [N-1:0]        gnt,
  output logic                busy
);

  localparam int unsigned PTR_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  // Reject parameter sets the arbiter is not built for.
  if (N < 2 || N > 8 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_err
    $error("powlib_ipmaxi_wrarb: illegal parameter set");
  end

  logic             state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  logic [B_AW-1:0]  addr_a [N];
  logic [B_DW-1:0]  data_a [N];
  logic [B_BPD-1:0] be_a   [N];

  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] cand;
  logic             accept_c;
  logic             last_c;
  logic             release_c;

  // Split the flat request buses into per-requester slices.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_slice
    assign addr_a[gi] = reqaddr[gi*B_AW +: B_AW];
    assign data_a[gi] = reqdata[gi*B_DW +: B_DW];
    assign be_a[gi]   = reqbe[gi*B_BPD +: B_BPD];
  end

  // Round-robin pick: first valid requester at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % int'(N));
      if (!sel_found && reqvld[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Downstream mux of the granted slice; everything is quiet while idle.
  always_comb begin
    wraddr = '0;
    wrdata = '0;
    wrbe   = '0;
    wrvld  = 1'b0;
    reqrdy = '0;
    if (state_q == ST_LOCK) begin
      wraddr = addr_a[gidx_q];
      wrdata = data_a[gidx_q];
      wrbe   = be_a[gidx_q];
      wrvld  = reqvld[gidx_q];
      reqrdy = gnt_q & {N{wrrdy}};
    end
  end

  assign accept_c = wrvld & wrrdy;
  assign last_c   = reqlast[gidx_q];

  // Next-state: grant in IDLE, count beats and decide release in LOCK.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    release_c = 1'b0;
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
        idle_d = '0;
`endif
        if (sel_found) begin
          state_d = ST_LOCK;
          gnt_d   = N'(1) << sel_idx;
          gidx_d  = sel_idx;
        end
      end
      ST_LOCK: begin
        if (accept_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
            release_c = 1'b1;
          end
        end
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
        if (reqvld[gidx_q]) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
          if (idle_d == IDLE_W'(TIMEOUT)) begin
            release_c = 1'b1;
          end
        end
`endif
        if (release_c) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == PTR_W'(N - 1)) ? '0 : gidx_q + PTR_W'(1);
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == ST_LOCK);

endmodule

// File: tb/tb_powlib_ipmaxi_wrarb.sv
// Scoreboard bench for powlib_ipmaxi_wrarb (N=2, MAX_BURST=4).
// Stimulus loads per-requester beat queues plus expected beats/grant snapshots;
// a driver process plays the beat queues, a monitor process does all checking.

module tb_powlib_ipmaxi_wrarb;

  localparam int unsigned N   = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned BPD = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned MB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*AW-1:0]  reqaddr;
  logic [N*DW-1:0]  reqdata;
  logic [N*BPD-1:0] reqbe;
  logic [N-1:0]     reqlast;
  logic [N-1:0]     reqvld;
  logic [N-1:0]     reqrdy;
  logic [AW-1:0]    wraddr;
  logic [DW-1:0]    wrdata;
  logic [BPD-1:0]   wrbe;
  logic             wrvld;
  logic             wrrdy;
  logic [N-1:0]     gnt;
  logic             busy;

  always #5 clk = ~clk;

  powlib_ipmaxi_wrarb #(
    .N(N), .B_AW(AW), .B_BPD(BPD), .MAX_BURST(MB), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .reqaddr(reqaddr), .reqdata(reqdata), .reqbe(reqbe),
    .reqlast(reqlast), .reqvld(reqvld), .reqrdy(reqrdy),
    .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe),
    .wrvld(wrvld), .wrrdy(wrrdy),
    .gnt(gnt), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  gnt;
  } exp_t;

  typedef struct {
    int         tag;
    logic [1:0] gnt;
    logic       drain;
  } snap_t;

  beat_t rq0[$];
  beat_t rq1[$];
  exp_t  exp_q[$];
  snap_t snap_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: grant snapshots first, then any beat crossing downstream.
  initial begin
    snap_t s;
    exp_t  e;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk($sformatf("gnt#%0d", s.tag), 32'(gnt), 32'(s.gnt));
        chk($sformatf("busy#%0d", s.tag), 32'(busy), 32'(s.gnt != 2'b00));
        if (s.gnt == 2'b00) begin
          chk($sformatf("idle_wrvld#%0d", s.tag), 32'(wrvld), 32'd0);
          chk($sformatf("idle_reqrdy#%0d", s.tag), 32'(reqrdy), 32'd0);
          chk($sformatf("idle_wraddr#%0d", s.tag), wraddr, 32'd0);
        end
        if (s.drain) chk($sformatf("drain#%0d", s.tag), 32'(exp_q.size()), 32'd0);
      end
      if (wrvld) chk("reqrdy_vs_wrrdy", 32'(reqrdy), 32'(gnt & {N{wrrdy}}));
      if (wrvld && wrrdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got addr 0x%0h, required no beat (t=%0t)", wraddr, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", wraddr, e.addr);
          chk("beat_data", wrdata, e.data);
          chk("beat_be", 32'(wrbe), 32'(e.be));
          chk("beat_gnt", 32'(gnt), 32'(e.gnt));
        end
      end
    end
  end

  // Driver: presents queue heads, pops a head once it was accepted.
  initial begin
    logic [N-1:0] acc;
    reqaddr = '0; reqdata = '0; reqbe = '0; reqlast = '0; reqvld = '0;
    forever begin
      @(negedge clk);
      acc = reqvld & reqrdy;
      @(posedge clk);
      #1;
      if (acc[0] && rq0.size() > 0) rq0.delete(0);
      if (acc[1] && rq1.size() > 0) rq1.delete(0);
      if (rq0.size() > 0) begin
        reqvld[0] = 1'b1; reqaddr[31:0] = rq0[0].addr; reqdata[31:0] = rq0[0].data;
        reqbe[3:0] = rq0[0].be; reqlast[0] = rq0[0].last;
      end else begin
        reqvld[0] = 1'b0; reqaddr[31:0] = '0; reqdata[31:0] = '0; reqbe[3:0] = '0; reqlast[0] = 1'b0;
      end
      if (rq1.size() > 0) begin
        reqvld[1] = 1'b1; reqaddr[63:32] = rq1[0].addr; reqdata[63:32] = rq1[0].data;
        reqbe[7:4] = rq1[0].be; reqlast[1] = rq1[0].last;
      end else begin
        reqvld[1] = 1'b0; reqaddr[63:32] = '0; reqdata[63:32] = '0; reqbe[7:4] = '0; reqlast[1] = 1'b0;
      end
    end
  end

  task automatic load(input int r, input logic [31:0] base, input int n, input bit term, input bit want);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      exp_t  e;
      b.addr = base + 32'(4 * k);
      b.data = 32'hD000_0000 | (32'(r) << 24) | (base + 32'(k));
      b.be   = 4'((k % 15) + 1);
      b.last = term && (k == n - 1);
      e.addr = b.addr;
      e.data = b.data;
      e.be   = b.be;
      e.gnt  = (r == 0) ? 2'b01 : 2'b10;
      if (r == 0) rq0.push_back(b);
      else        rq1.push_back(b);
      if (want) exp_q.push_back(e);
    end
  endtask

  task automatic push_snap(input int tag, input logic [1:0] g, input logic drain);
    snap_t s;
    s.tag   = tag;
    s.gnt   = g;
    s.drain = drain;
    snap_q.push_back(s);
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_seq(input int tag0, input logic [1:0] sq[$]);
    for (int c = 0; c < sq.size(); c++) begin
      @(posedge clk);
      #2;
      push_snap(tag0 + c, sq[c], 1'b0);
    end
  endtask

  task automatic drain(input int tag);
    repeat (2) @(posedge clk);
    #2;
    push_snap(tag, 2'b00, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] sq[$];
    wrrdy = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    push_snap(0, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester, 4 beats; leaves ptr = 1.
    mid_cycle();
    load(0, 32'h100, 4, 1'b1, 1'b1);
    sq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    run_seq(10, sq);
    drain(19);

    // ptr = 1: requester 1 wins over requester 0.
    mid_cycle();
    load(1, 32'h180, 1, 1'b1, 1'b1);
    load(0, 32'h1C0, 1, 1'b1, 1'b1);
    sq = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    run_seq(20, sq);
    drain(29);

    // Contention after reset: req0, bubble, req1.
    pulse_reset();
    mid_cycle();
    load(0, 32'h200, 2, 1'b1, 1'b1);
    load(1, 32'h240, 2, 1'b1, 1'b1);
    sq = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    run_seq(30, sq);
    drain(39);

    // Burst cap: 10 beats split 4/4/2.
    mid_cycle();
    load(1, 32'h400, 10, 1'b1, 1'b1);
    sq = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
           2'b00, 2'b10, 2'b10, 2'b00};
    run_seq(40, sq);
    drain(59);

    // Backpressure: wrrdy toggles every cycle during a 3-beat transaction.
    mid_cycle();
    load(0, 32'h500, 3, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      wrrdy = ~wrrdy;
    end
    @(posedge clk);
    #1;
    wrrdy = 1'b1;
    drain(69);

    // Reset after beat 2 of 5, then restart from ptr = 0.
    mid_cycle();
    load(0, 32'h600, 5, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    push_snap(70, 2'b00, 1'b0);
    rq0.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mid_cycle();
    load(0, 32'h700, 1, 1'b1, 1'b1);
    load(1, 32'h740, 1, 1'b1, 1'b1);
    sq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    run_seq(71, sq);
    drain(79);

    // Granted requester stalls without reqlast while req1 waits.
    mid_cycle();
`ifdef POWLIB_IPMAXI_WRARB_TIMEOUT_EN
    load(0, 32'h800, 1, 1'b0, 1'b1);
    load(1, 32'h840, 1, 1'b1, 1'b1);
    for (int c = 0; c < 60 && gnt != 2'b10; c++) @(posedge clk);
    #2;
    push_snap(80, 2'b10, 1'b0);
    drain(89);
`else
    load(0, 32'h800, 1, 1'b0, 1'b1);
    load(1, 32'h840, 1, 1'b1, 1'b0);
    sq.delete();
    sq.push_back(2'b00);
    repeat (30) sq.push_back(2'b01);
    run_seq(80, sq);
    @(negedge clk);
    rst = 1'b0;
    rq0.delete();
    rq1.delete();
    @(negedge clk);
    rst = 1'b1;
    drain(119);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
